mem_lsu: RTL and testbench
==========================

Name: mem_lsu

Overview:
- Load/store unit directly upstream of the word-wide single-port block-RAM memory stage.
- Converts CPU byte/halfword/word requests into the memory's word-only read/write protocol.
- Memory protocol: one-cycle read latency, word write, no byte enables.
- Sub-word stores use read-modify-write; loads are lane-extracted and sign- or zero-extended.

Parameters:
- ADDR_W, 7: byte address width on both the request side and the memory side.
- DATA_W, 32: data width. Fixed at 32; other values are unsupported.

Ports:
- clk  input  1  system clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- i_req_valid  input  1  request present.
- o_req_ready  output  1  unit can accept a request; high only in IDLE.
- i_req_we  input  1  1 = store, 0 = load.
- i_req_size  input  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- i_req_unsigned  input  1  loads only: zero-extend instead of sign-extend.
- i_req_addr  input  ADDR_W  byte address.
- i_req_wdata  input  32  store data, right-aligned.
- o_rsp_valid  output  1  one-cycle completion pulse; the consumer cannot stall it.
- o_rsp_rdata  output  32  load result; 0 for stores.
- o_rsp_err  output  1  misaligned access (LSU_ERR_EN only).
- o_mem_addr  output  ADDR_W  word address to memory; bits [1:0] always 0.
- o_mem_data  output  32  write data to memory.
- o_mem_rw  output  1  1 = write, 0 = read.
- i_mem_data  input  32  memory read data; valid the cycle after a read edge.

Behaviour:
- Reset (async, resetn low):
  - state = IDLE.
  - o_req_ready = 1; o_rsp_valid, o_rsp_rdata, o_rsp_err = 0.
  - o_mem_rw = 0, o_mem_addr = 0, o_mem_data = 0.
  - All latched request fields = 0.
- o_mem_rw is decoded from state. It is 1 only in WRITE, so reset asserted in any state drops it immediately.
- Handshake: accept on clk edge with i_req_valid && o_req_ready. Request fields are latched at that edge. i_req_valid outside IDLE is ignored; no queueing.
- FSM:
  - IDLE → RESP on misaligned access (LSU_ERR_EN only).
  - IDLE → WRITE on word store.
  - IDLE → READ otherwise.
  - READ: o_mem_rw = 0, o_mem_addr = latched address. → CAPTURE.
  - CAPTURE: i_mem_data valid.
    - Load: register the extracted result into o_rsp_rdata. → RESP.
    - Store: register the merged word. → WRITE.
  - WRITE: o_mem_rw = 1, o_mem_data = merged word (or wdata for a word store). → RESP.
  - RESP: o_rsp_valid = 1 for exactly this cycle. → IDLE.
  - o_req_ready returns to 1 in the following cycle.
- Latency (cycles from accept edge to the cycle o_rsp_valid is high):
  - Word store: 2.
  - Load: 3.
  - Sub-word store: 4.
  - Misaligned: 1.
- Lanes are little-endian: byte k occupies bits [8k+7:8k].
  - Byte lane = addr[1:0]; half lane = addr[1].
  - Loads are sign-extended from bit 7 or bit 15 unless the latched unsigned flag is set.
  - Merge replaces only the addressed lane with low bits of wdata; other lanes keep the read value.
- Alignment: half is misaligned if addr[0] = 1; word is misaligned if addr[1:0] != 0. Byte accesses are never misaligned.
- o_rsp_rdata and o_rsp_err hold their value until the next RESP; stores drive rdata 0.
- Reset mid-operation: the in-flight request is dropped and no response is issued. A reset during WRITE suppresses the write, because rw falls asynchronously before the edge.

Optional Feature:
- Macro: MEM_LSU_ERR_EN.
- Defined:
  - A misaligned request goes IDLE → RESP with o_rsp_err = 1 and o_rsp_rdata = 0.
  - No memory access occurs.
- Undefined:
  - Offending low address bits are cleared (forced to natural alignment) and the access proceeds normally.
  - o_rsp_err is tied 0.

Decomposition:
- Package mem_lsu_pkg:
  - Size encodings SZ_BYTE / SZ_HALF / SZ_WORD.
  - FSM state typedef (IDLE, READ, CAPTURE, WRITE, RESP).
  - DATA_W constant.
- Sub-module mem_lsu_lane: purely combinational.
  - Inputs: size, addr[1:0], unsigned, rdata, wdata.
  - Outputs: load_data (extracted and extended), merged_word.
  - Keeps the FSM file free of lane muxing.

Test Plan:
- Memory word 0x10 = 0x80FF7F01.
  - Byte load 0x13 signed → rdata 0xFFFFFF80.
  - Same load with unsigned → 0x00000080.
  - o_rsp_valid 3 cycles after accept.
- Half store 0xBEEF to 0x12 over 0x80FF7F01 → exactly one o_mem_rw = 1 cycle, memory word becomes 0xBEEF7F01, o_rsp_valid at cycle 4.
- Word store 0xDEADBEEF to 0x20 → write on cycle 1, rsp at cycle 2. A following word load from 0x20 returns 0xDEADBEEF.
- Half load from 0x11:
  - With MEM_LSU_ERR_EN → rsp at cycle 1, err = 1, rdata 0, o_mem_rw never 1.
  - Without → access aligned to 0x10, rdata 0x00007F01.
- resetn pulsed low while in WRITE of a byte store to 0x10 → o_mem_rw falls the same cycle, memory stays 0x80FF7F01, no o_rsp_valid, o_req_ready = 1 after release.
- i_req_valid held high across a whole load → second request accepted only on the cycle after RESP (ready pattern 1,0,0,0,1). Exactly one response per accept.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// Shared types for the load/store unit: access sizes, FSM states, lane helpers.
package mem_lsu_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_CAPTURE,
    ST_WRITE,
    ST_RESP
  } state_e;

  // Encoding 3 is folded onto word.
  function automatic size_e norm_size(input logic [1:0] s);
    case (s)
      2'd0:    norm_size = SZ_BYTE;
      2'd1:    norm_size = SZ_HALF;
      default: norm_size = SZ_WORD;
    endcase
  endfunction

  function automatic logic misaligned(input size_e s, input logic [1:0] a);
    case (s)
      SZ_HALF: misaligned = a[0];
      SZ_WORD: misaligned = |a;
      default: misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] align_lo(input size_e s, input logic [1:0] a);
    case (s)
      SZ_HALF: align_lo = {a[1], 1'b0};
      SZ_WORD: align_lo = 2'b00;
      default: align_lo = a;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// CPU-side request/response bundle of the load/store unit.
interface mem_lsu_if #(parameter int ADDR_W = 7);
  logic              i_req_valid;
  logic              o_req_ready;
  logic              i_req_we;
  logic [1:0]        i_req_size;
  logic              i_req_unsigned;
  logic [ADDR_W-1:0] i_req_addr;
  logic [31:0]       i_req_wdata;
  logic              o_rsp_valid;
  logic [31:0]       o_rsp_rdata;
  logic              o_rsp_err;

  modport slave (
    input  i_req_valid, i_req_we, i_req_size, i_req_unsigned, i_req_addr, i_req_wdata,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
  );

  modport master (
    output i_req_valid, i_req_we, i_req_size, i_req_unsigned, i_req_addr, i_req_wdata,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
  );
endinterface

// File: rtl/mem_lsu_lane.sv
// Lane extraction/extension for loads and lane merge for sub-word stores.
module mem_lsu_lane
  import mem_lsu_pkg::*;
(
  input  size_e             size,
  input  logic [1:0]        addr_lo,
  input  logic              uns,
  input  logic [DATA_W-1:0] rdata,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] merged_word
);
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v      = rdata[{addr_lo, 3'b000} +: 8];
    half_v      = rdata[{addr_lo[1], 4'b0000} +: 16];
    load_data   = rdata;
    merged_word = wdata;
    case (size)
      SZ_BYTE: begin
        load_data   = {{24{~uns & byte_v[7]}}, byte_v};
        merged_word = rdata;
        merged_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_data   = {{16{~uns & half_v[15]}}, half_v};
        merged_word = rdata;
        merged_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/mem_lsu.sv
// Byte/half/word load-store unit over a word-only, 1-cycle-latency RAM.
// Optional misaligned-access error response: MEM_LSU_ERR_EN.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              resetn,
  mem_lsu_if.slave          req,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_data,
  output logic              o_mem_rw,
  input  logic [31:0]       i_mem_data
);
  state_e            state_q, state_d;
  logic              we_q, we_d, uns_q, uns_d, err_q, err_d;
  size_e             size_q, size_d, acc_size;
  logic [ADDR_W-1:0] addr_q, addr_d, acc_addr;
  logic [31:0]       wd_q, wd_d, rdata_q, rdata_d;
  logic [31:0]       load_data, merged_word;
  logic              acc_err;

  mem_lsu_lane u_lane (
    .size        (size_q),
    .addr_lo     (addr_q[1:0]),
    .uns         (uns_q),
    .rdata       (i_mem_data),
    .wdata       (wd_q),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    size_d   = size_q;
    uns_d    = uns_q;
    addr_d   = addr_q;
    wd_d     = wd_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    acc_size = norm_size(req.i_req_size);
    acc_addr = req.i_req_addr;
`ifdef MEM_LSU_ERR_EN
    acc_err  = misaligned(acc_size, req.i_req_addr[1:0]);
`else
    // Without error reporting, misaligned accesses snap to natural alignment.
    acc_err  = 1'b0;
    acc_addr[1:0] = align_lo(acc_size, req.i_req_addr[1:0]);
`endif
    case (state_q)
      ST_IDLE: if (req.i_req_valid) begin
        we_d   = req.i_req_we;
        size_d = acc_size;
        uns_d  = req.i_req_unsigned;
        addr_d = acc_addr;
        wd_d   = req.i_req_wdata;
        if (acc_err) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else if (req.i_req_we && acc_size == SZ_WORD) begin
          state_d = ST_WRITE;
        end else begin
          state_d = ST_READ;
        end
      end
      ST_READ: state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        if (we_q) begin
          wd_d    = merged_word;
          state_d = ST_WRITE;
        end else begin
          rdata_d = load_data;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end
      end
      ST_WRITE: begin
        rdata_d = '0;
        err_d   = 1'b0;
        state_d = ST_RESP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // rw decodes straight from state so an async reset kills a pending write.
  assign o_mem_rw        = (state_q == ST_WRITE);
  assign o_mem_addr      = {addr_q[ADDR_W-1:2], 2'b00};
  assign o_mem_data      = wd_q;
  assign req.o_req_ready = (state_q == ST_IDLE);
  assign req.o_rsp_valid = (state_q == ST_RESP);
  assign req.o_rsp_rdata = rdata_q;
  assign req.o_rsp_err   = err_q;
endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: directed vector table, hand sequences, random vs byte-array model.
module tb_mem_lsu;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [6:0]  o_mem_addr;
  logic [31:0] o_mem_data, i_mem_data;
  logic        o_mem_rw;

  mem_lsu_if #(.ADDR_W(7)) bus ();

  mem_lsu #(.ADDR_W(7)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req        (bus),
    .o_mem_addr (o_mem_addr),
    .o_mem_data (o_mem_data),
    .o_mem_rw   (o_mem_rw),
    .i_mem_data (i_mem_data)
  );

  always #5 clk = ~clk;

  // Block RAM model with a side port for preloading.
  logic [31:0] mem [32];
  logic        poke_en = 1'b0;
  logic [4:0]  poke_idx = '0;
  logic [31:0] poke_val = '0;
  int wr_cnt = 0, rsp_cnt = 0, acc_cnt = 0;

  always @(posedge clk) begin
    if (poke_en) mem[poke_idx] <= poke_val;
    else if (o_mem_rw) mem[o_mem_addr[6:2]] <= o_mem_data;
    i_mem_data <= mem[o_mem_addr[6:2]];
    if (o_mem_rw) wr_cnt <= wr_cnt + 1;
    if (bus.o_rsp_valid) rsp_cnt <= rsp_cnt + 1;
    if (bus.i_req_valid && bus.o_req_ready) acc_cnt <= acc_cnt + 1;
  end

  int total = 0, bad = 0;
  logic [7:0] refm [128];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic poke(input logic [4:0] idx, input logic [31:0] val);
    @(negedge clk);
    poke_en = 1'b1; poke_idx = idx; poke_val = val;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic do_op(input logic we, input logic [1:0] size, input logic uns,
                       input logic [6:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err,
                       output int lat, output int wrs);
    int w0;
    @(negedge clk);
    bus.i_req_valid = 1'b1; bus.i_req_we = we; bus.i_req_size = size;
    bus.i_req_unsigned = uns; bus.i_req_addr = addr; bus.i_req_wdata = wdata;
    @(posedge clk);
    w0 = wr_cnt;
    #1 bus.i_req_valid = 1'b0;
    lat = 0; rdata = 'x; err = 1'bx;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(negedge clk);
      if (bus.o_rsp_valid) begin
        lat = c; rdata = bus.o_rsp_rdata; err = bus.o_rsp_err;
      end
    end
    wrs = wr_cnt - w0;
  endtask

  typedef struct {
    logic we; logic [1:0] size; logic uns; logic [6:0] addr; logic [31:0] wdata;
    logic [31:0] exp_rdata; int exp_lat; logic exp_err; int exp_wr;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [6:0] addr, input logic [31:0] wdata,
                              input logic [31:0] er, input int el, input logic ee, input int ew);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = er; v.exp_lat = el; v.exp_err = ee; v.exp_wr = ew;
    return v;
  endfunction

  // Reference: plain byte-addressed memory, access rules applied directly.
  task automatic ref_op(input logic we, input logic [1:0] size, input logic uns,
                        input int addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err,
                        output int lat, output int wrs);
    int nb, a;
    logic [31:0] v;
    nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    err = 1'b0; rdata = '0; wrs = 0;
`ifdef MEM_LSU_ERR_EN
    if (addr % nb != 0) begin
      err = 1'b1; lat = 1;
      return;
    end
`endif
    a = addr - (addr % nb);
    if (we) begin
      for (int i = 0; i < nb; i++) refm[a + i] = wdata[8*i +: 8];
      lat = (nb == 4) ? 2 : 4;
      wrs = 1;
    end else begin
      v = '0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = refm[a + i];
      if (!uns && nb < 4 && v[8*nb - 1]) v = v | (32'hFFFF_FFFF << (8*nb));
      rdata = v;
      lat = 3;
    end
  endtask

  initial begin
    vec_t tv [13];
    logic [31:0] rd, erd, w;
    logic er, eer;
    int lat, elat, wrs, ewrs, r0, a0;
    logic [4:0] pat;

    bus.i_req_valid = 1'b0; bus.i_req_we = 1'b0; bus.i_req_size = '0;
    bus.i_req_unsigned = 1'b0; bus.i_req_addr = '0; bus.i_req_wdata = '0;

    for (int i = 0; i < 128; i++) refm[i] = 8'($urandom);
    {refm[19], refm[18], refm[17], refm[16]} = 32'h80FF7F01;
    for (int i = 0; i < 32; i++)
      poke(5'(i), {refm[4*i+3], refm[4*i+2], refm[4*i+1], refm[4*i]});

    // Reset state
    @(negedge clk);
    chk("rst_ready", 32'(bus.o_req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
    chk("rst_rdata", bus.o_rsp_rdata, 32'd0);
    chk("rst_err", 32'(bus.o_rsp_err), 32'd0);
    chk("rst_mem_rw", 32'(o_mem_rw), 32'd0);
    chk("rst_mem_addr", 32'(o_mem_addr), 32'd0);
    chk("rst_mem_data", o_mem_data, 32'd0);
    resetn = 1'b1;

    tv[0]  = mk(0, 0, 0, 7'h13, 0,            32'hFFFFFF80, 3, 0, 0);
    tv[1]  = mk(0, 0, 1, 7'h13, 0,            32'h00000080, 3, 0, 0);
    tv[2]  = mk(0, 1, 0, 7'h10, 0,            32'h00007F01, 3, 0, 0);
    tv[3]  = mk(0, 1, 0, 7'h12, 0,            32'hFFFF80FF, 3, 0, 0);
    tv[4]  = mk(0, 0, 0, 7'h11, 0,            32'h0000007F, 3, 0, 0);
    tv[5]  = mk(0, 2, 0, 7'h10, 0,            32'h80FF7F01, 3, 0, 0);
    tv[6]  = mk(1, 1, 0, 7'h12, 32'h0000BEEF, 32'h0,        4, 0, 1);
    tv[7]  = mk(0, 3, 0, 7'h10, 0,            32'hBEEF7F01, 3, 0, 0);
    tv[8]  = mk(1, 2, 0, 7'h20, 32'hDEADBEEF, 32'h0,        2, 0, 1);
    tv[9]  = mk(0, 2, 0, 7'h20, 0,            32'hDEADBEEF, 3, 0, 0);
    tv[10] = mk(1, 0, 0, 7'h21, 32'h123456AA, 32'h0,        4, 0, 1);
    tv[11] = mk(0, 2, 0, 7'h20, 0,            32'hDEADAAEF, 3, 0, 0);
`ifdef MEM_LSU_ERR_EN
    tv[12] = mk(0, 1, 0, 7'h11, 0,            32'h0,        1, 1, 0);
`else
    tv[12] = mk(0, 1, 0, 7'h11, 0,            32'h00007F01, 3, 0, 0);
`endif
    for (int i = 0; i < 13; i++) begin
      do_op(tv[i].we, tv[i].size, tv[i].uns, tv[i].addr, tv[i].wdata, rd, er, lat, wrs);
      chk($sformatf("vec%0d_rdata", i), rd, tv[i].exp_rdata);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(tv[i].exp_lat));
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(tv[i].exp_err));
      chk($sformatf("vec%0d_writes", i), 32'(wrs), 32'(tv[i].exp_wr));
    end
    chk("half_store_word", mem[8'h10 >> 2], 32'hBEEF7F01);

    // Reset asserted while a byte store sits in WRITE
    poke(5'd4, 32'h80FF7F01);
    @(negedge clk);
    bus.i_req_valid = 1'b1; bus.i_req_we = 1'b1; bus.i_req_size = 2'd0;
    bus.i_req_unsigned = 1'b0; bus.i_req_addr = 7'h10; bus.i_req_wdata = 32'h55;
    @(posedge clk);
    r0 = rsp_cnt;
    #1 bus.i_req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_rw_before", 32'(o_mem_rw), 32'd1);
    resetn = 1'b0;
    #1 chk("midrst_rw_drop", 32'(o_mem_rw), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    chk("midrst_mem", mem[4], 32'h80FF7F01);
    chk("midrst_no_rsp", 32'(rsp_cnt - r0), 32'd0);
    chk("midrst_ready", 32'(bus.o_req_ready), 32'd1);

    // Valid held high across a load: ready pattern 1,0,0,0,1
    r0 = rsp_cnt; a0 = acc_cnt;
    @(negedge clk);
    bus.i_req_valid = 1'b1; bus.i_req_we = 1'b0; bus.i_req_size = 2'd2; bus.i_req_addr = 7'h10;
    pat[4] = bus.o_req_ready;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      pat[4 - c] = bus.o_req_ready;
    end
    @(posedge clk);
    #1 bus.i_req_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("hold_ready_pattern", 32'(pat), 32'b10001);
    chk("hold_accepts", 32'(acc_cnt - a0), 32'd2);
    chk("hold_responses", 32'(rsp_cnt - r0), 32'd2);

    // Random traffic against the byte-array model
    for (int i = 0; i < 32; i++)
      poke(5'(i), {refm[4*i+3], refm[4*i+2], refm[4*i+1], refm[4*i]});
    for (int n = 0; n < 200; n++) begin
      logic rwe, runs;
      logic [1:0] rsz;
      logic [6:0] ra;
      rwe = 1'($urandom); rsz = 2'($urandom); runs = 1'($urandom);
      ra = 7'($urandom); w = $urandom;
      do_op(rwe, rsz, runs, ra, w, rd, er, lat, wrs);
      ref_op(rwe, rsz, runs, int'(ra), w, erd, eer, elat, ewrs);
      chk($sformatf("rnd%0d_rdata", n), rd, erd);
      chk($sformatf("rnd%0d_lat", n), 32'(lat), 32'(elat));
      chk($sformatf("rnd%0d_err", n), 32'(er), 32'(eer));
      chk($sformatf("rnd%0d_writes", n), 32'(wrs), 32'(ewrs));
    end
    for (int i = 0; i < 32; i++)
      chk($sformatf("final_mem%0d", i), mem[i],
          {refm[4*i+3], refm[4*i+2], refm[4*i+1], refm[4*i]});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
